// File: rtl/rvcpu.sv
// Shared CPU-wide types: architectural register index.
package rvcpu;
    typedef logic [4:0] reg_t;
endpackage

// File: rtl/reg_scoreboard.sv
// Register scoreboard: counts outstanding writes per integer register and
// stalls issue on RAW hazards or when a destination's pending counter is full.
module reg_scoreboard #(
    parameter int NREGS    = 32,
    parameter int MAX_PEND = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               issue_vld,
    output logic               issue_rdy,
    input  rvcpu::reg_t        issue_rs1,
    input  rvcpu::reg_t        issue_rs2,
    input  logic               issue_rs1_vld,
    input  logic               issue_rs2_vld,
    input  rvcpu::reg_t        issue_rd,
    input  logic               issue_rd_vld,
    input  logic               wb_vld,
    input  rvcpu::reg_t        wb_rd,
    input  logic               flush,
    output logic [NREGS-1:0]   busy_mask,
    output logic               wb_err
);

    localparam int CW   = $clog2(MAX_PEND + 1);
    localparam int NIDX = 2 ** $bits(rvcpu::reg_t);

    logic [CW-1:0]   r_cnt [NREGS];
    logic            r_wb_err;
    logic [NIDX-1:0] w_busy_ext;
    logic [NIDX-1:0] w_full_ext;
    logic            w_src_hazard;
    logic            w_rd_full;
    logic            w_fire;

    // Status vectors are padded to the full index space so any reg_t value
    // can index them; x0 and unimplemented indices read as idle.
    genvar gi;
    generate
        for (gi = 0; gi < NIDX; gi++) begin : g_status
            if (gi == 0 || gi >= NREGS) begin : g_idle
                assign w_busy_ext[gi] = 1'b0;
                assign w_full_ext[gi] = 1'b0;
            end else begin : g_live
                assign w_busy_ext[gi] = (r_cnt[gi] != '0);
                assign w_full_ext[gi] = (r_cnt[gi] == CW'(MAX_PEND));
            end
        end
    endgenerate

    assign w_src_hazard = (issue_rs1_vld && issue_rs1 != '0 && w_busy_ext[issue_rs1]) ||
                          (issue_rs2_vld && issue_rs2 != '0 && w_busy_ext[issue_rs2]);
    assign w_rd_full    = issue_rd_vld && issue_rd != '0 && w_full_ext[issue_rd];
    assign issue_rdy    = !w_src_hazard && !w_rd_full && !flush;
    assign w_fire       = issue_vld && issue_rdy;

    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_cnt
            if (gi == 0) begin : g_x0
                assign r_cnt[gi] = '0;
            end else begin : g_reg
                logic w_inc;
                logic w_dec;

                assign w_inc = w_fire && issue_rd_vld && (issue_rd == rvcpu::reg_t'(gi));
                assign w_dec = wb_vld && (wb_rd == rvcpu::reg_t'(gi));

                // A same-cycle issue and writeback to one register cancel out.
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        r_cnt[gi] <= '0;
                    end else if (flush) begin
                        r_cnt[gi] <= '0;
                    end else if (w_inc && !w_dec) begin
                        r_cnt[gi] <= r_cnt[gi] + CW'(1);
                    end else if (w_dec && !w_inc && r_cnt[gi] != '0) begin
                        r_cnt[gi] <= r_cnt[gi] - CW'(1);
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wb_err <= 1'b0;
        end else if (!flush && wb_vld && wb_rd != '0 && !w_busy_ext[wb_rd]) begin
            r_wb_err <= 1'b1;
        end
    end

    assign busy_mask = w_busy_ext[NREGS-1:0];
    assign wb_err    = r_wb_err;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: RAW, saturation, simultaneous events,
// x0, flush/error and asynchronous reset.
module tb_reg_scoreboard;

    logic        clk;
    logic        rst;
    logic        issue_vld;
    logic        issue_rdy;
    rvcpu::reg_t issue_rs1;
    rvcpu::reg_t issue_rs2;
    logic        issue_rs1_vld;
    logic        issue_rs2_vld;
    rvcpu::reg_t issue_rd;
    logic        issue_rd_vld;
    logic        wb_vld;
    rvcpu::reg_t wb_rd;
    logic        flush;
    logic [31:0] busy_mask;
    logic        wb_err;

    int n_cmp;
    int n_err;

    reg_scoreboard #(.NREGS(32), .MAX_PEND(3)) dut (
        .clk           (clk),
        .rst           (rst),
        .issue_vld     (issue_vld),
        .issue_rdy     (issue_rdy),
        .issue_rs1     (issue_rs1),
        .issue_rs2     (issue_rs2),
        .issue_rs1_vld (issue_rs1_vld),
        .issue_rs2_vld (issue_rs2_vld),
        .issue_rd      (issue_rd),
        .issue_rd_vld  (issue_rd_vld),
        .wb_vld        (wb_vld),
        .wb_rd         (wb_rd),
        .flush         (flush),
        .busy_mask     (busy_mask),
        .wb_err        (wb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %-14s observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic idle();
        issue_vld     = 1'b0;
        issue_rs1     = '0;
        issue_rs2     = '0;
        issue_rs1_vld = 1'b0;
        issue_rs2_vld = 1'b0;
        issue_rd      = '0;
        issue_rd_vld  = 1'b0;
        wb_vld        = 1'b0;
        wb_rd         = '0;
        flush         = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_to(input rvcpu::reg_t rd);
        issue_vld    = 1'b1;
        issue_rd     = rd;
        issue_rd_vld = 1'b1;
    endtask

    task automatic wb_to(input rvcpu::reg_t rd);
        wb_vld = 1'b1;
        wb_rd  = rd;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        idle();
        #2;
        // Offer under reset: ready, but must not take effect
        issue_to(5'd5);
        issue_rs1 = 5'd5; issue_rs1_vld = 1'b1;
        wb_to(5'd8);
        #1;
        chk("rst_busy", busy_mask, 32'h0);
        chk("rst_err", {31'b0, wb_err}, 32'h0);
        chk("rst_rdy", {31'b0, issue_rdy}, 32'h1);
        tick();
        chk("rst_discard", busy_mask, 32'h0);
        chk("rst_disc_err", {31'b0, wb_err}, 32'h0);
        rst = 1'b0;
        idle();

        // Basic RAW on x5
        issue_to(5'd5); #1;
        chk("raw_first_rdy", {31'b0, issue_rdy}, 32'h1);
        tick(); idle();
        issue_vld = 1'b1; issue_rs1 = 5'd5; issue_rs1_vld = 1'b1; #1;
        chk("raw_rs1_stall", {31'b0, issue_rdy}, 32'h0);
        chk("raw_busy", busy_mask, 32'h0000_0020);
        issue_rs1_vld = 1'b0; issue_rs2 = 5'd5; issue_rs2_vld = 1'b1; #1;
        chk("raw_rs2_stall", {31'b0, issue_rdy}, 32'h0);
        wb_to(5'd5); #1;
        chk("raw_no_bypass", {31'b0, issue_rdy}, 32'h0);
        tick(); idle();
        issue_vld = 1'b1; issue_rs2 = 5'd5; issue_rs2_vld = 1'b1; #1;
        chk("raw_clear_rdy", {31'b0, issue_rdy}, 32'h1);
        chk("raw_clear_busy", busy_mask, 32'h0);
        idle();

        // Saturation on x7
        for (int i = 0; i < 3; i++) begin
            issue_to(5'd7); #1;
            chk("sat_issue_rdy", {31'b0, issue_rdy}, 32'h1);
            tick(); idle();
        end
        issue_to(5'd7); #1;
        chk("sat_full_rdy", {31'b0, issue_rdy}, 32'h0);
        chk("sat_busy", busy_mask, 32'h0000_0080);
        tick(); idle();
        issue_to(5'd7); wb_to(5'd7); #1;
        chk("sat_wb_same", {31'b0, issue_rdy}, 32'h0);
        tick(); idle();
        issue_rd = 5'd7; issue_rd_vld = 1'b1; #1;
        chk("sat_after_wb", {31'b0, issue_rdy}, 32'h1);
        idle();
        wb_to(5'd7); tick(); idle();
        chk("sat_drain1", busy_mask, 32'h0000_0080);
        wb_to(5'd7); tick(); idle();
        chk("sat_drained", busy_mask, 32'h0);
        chk("sat_err", {31'b0, wb_err}, 32'h0);

        // Simultaneous issue and writeback on x9
        issue_to(5'd9); tick(); idle();
        issue_to(5'd9); wb_to(5'd9); #1;
        chk("sim_rdy", {31'b0, issue_rdy}, 32'h1);
        tick(); idle();
        chk("sim_busy", busy_mask, 32'h0000_0200);
        wb_to(5'd9); tick(); idle();
        chk("sim_drain", busy_mask, 32'h0);
        chk("sim_err", {31'b0, wb_err}, 32'h0);

        // x0 is never tracked
        issue_to(5'd0); tick(); idle();
        issue_vld = 1'b1; issue_rs1 = 5'd0; issue_rs1_vld = 1'b1;
        issue_rd = 5'd0; issue_rd_vld = 1'b1; #1;
        chk("x0_rdy", {31'b0, issue_rdy}, 32'h1);
        chk("x0_busy", busy_mask, 32'h0);
        idle();
        wb_to(5'd0); tick(); idle();
        chk("x0_wb_err", {31'b0, wb_err}, 32'h0);

        // Flush overrides issue and wb; then a stray wb sets the sticky error
        issue_to(5'd3); tick(); idle();
        issue_to(5'd4); tick(); idle();
        chk("fl_busy", busy_mask, 32'h0000_0018);
        flush = 1'b1; issue_to(5'd6); wb_to(5'd11); #1;
        chk("fl_rdy", {31'b0, issue_rdy}, 32'h0);
        tick(); idle();
        chk("fl_cleared", busy_mask, 32'h0);
        chk("fl_no_err", {31'b0, wb_err}, 32'h0);
        wb_to(5'd3); tick(); idle();
        chk("err_set", {31'b0, wb_err}, 32'h1);
        chk("err_busy", busy_mask, 32'h0);
        flush = 1'b1; tick(); idle();
        chk("err_sticky", {31'b0, wb_err}, 32'h1);

        // Asynchronous reset between clock edges
        issue_to(5'd12); tick(); idle();
        chk("ar_busy", busy_mask, 32'h0000_1000);
        rst = 1'b1; #1;
        chk("ar_busy_now", busy_mask, 32'h0);
        chk("ar_err_now", {31'b0, wb_err}, 32'h0);
        issue_to(5'd13); wb_to(5'd14);
        tick();
        rst = 1'b0; idle(); #1;
        chk("ar_discard", busy_mask, 32'h0);
        chk("ar_disc_err", {31'b0, wb_err}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
